// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO responder.
// Holds frame field constants, field widths, frame bit indices (numbered
// from the first ST bit as rise 1..32) and the frame-decoder state type.
package mdio_pkg;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] TA_WR = 2'b10;

    localparam int unsigned PHYAD_W = 5;
    localparam int unsigned REGAD_W = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BIT_W   = 6;

    localparam logic [BIT_W-1:0] BIT_ADDR_END = 6'd14;
    localparam logic [BIT_W-1:0] BIT_TA1      = 6'd15;
    localparam logic [BIT_W-1:0] BIT_TA2      = 6'd16;
    localparam logic [BIT_W-1:0] BIT_LAST     = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_ADDR,
        S_TA,
        S_DATA,
        S_SKIP
    } state_t;

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings MDC and MDIO into the clk domain.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   mdc, mdi    : asynchronous pin inputs
//   rise, fall  : one-clk pulses on synchronized MDC edges (3 clks after pin edge)
//   mdi_r       : synchronized MDIO, delayed to line up with rise/fall
module mdio_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic mdc,
    input  logic mdi,
    output logic rise,
    output logic fall,
    output logic mdi_r
);

    logic mdc_m, mdc_s, mdc_q;
    logic mdi_m, mdi_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_m <= 1'b0;
            mdc_s <= 1'b0;
            mdc_q <= 1'b0;
            mdi_m <= 1'b0;
            mdi_s <= 1'b0;
            mdi_r <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            mdc_m <= mdc;
            mdc_s <= mdc_m;
            mdc_q <= mdc_s;
            mdi_m <= mdi;
            mdi_s <= mdi_m;
            // Third MDIO stage keeps data aligned with the registered edge pulses.
            mdi_r <= mdi_s;
            rise  <= mdc_s & ~mdc_q;
            fall  <= ~mdc_s & mdc_q;
        end
    end

endmodule

// File: rtl/mdio_slave.sv
// PHY-side Clause 22 MDIO responder serving a 32 x 16-bit register space.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   mdc, mdi   : management clock and MDIO pin input (asynchronous)
//   mdt, mdo   : MDIO output enable and data (pad: mdio = mdt ? mdo : z)
//   reg_addr   : register address of the current frame
//   reg_rd     : one-clk read strobe; reg_rdata valid on the following clk
//   reg_wr     : one-clk write strobe; reg_wdata valid with it and held after
//   frame_err  : one-clk pulse when a frame is aborted
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd1,
    parameter int unsigned        PRE_MIN  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mdc,
    input  logic               mdi,
    output logic               mdt,
    output logic               mdo,
    output logic [REGAD_W-1:0] reg_addr,
    output logic               reg_rd,
    input  logic [DATA_W-1:0]  reg_rdata,
    output logic               reg_wr,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               frame_err
);

    localparam int unsigned PW = $clog2(PRE_MIN + 2);

    logic              rise, fall, mdi_r;
    state_t            state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_nxt;
    logic [PW-1:0]     pre_cnt;
    logic              op_hi, ta_hi, is_read, rd_load;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic [9:0]        hdr;

    mdio_edge_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .mdc   (mdc),
        .mdi   (mdi),
        .rise  (rise),
        .fall  (fall),
        .mdi_r (mdi_r)
    );

    // bit_nxt is the frame bit number of the bit being sampled on this rise.
    assign bit_nxt = bit_cnt + 6'd1;
    // PHYAD/REGAD as they stand once the current bit is shifted in.
    assign hdr     = {rx_sr[8:0], mdi_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            op_hi     <= 1'b0;
            ta_hi     <= 1'b0;
            is_read   <= 1'b0;
            rd_load   <= 1'b0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            mdt       <= 1'b0;
            mdo       <= 1'b0;
            reg_addr  <= '0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            frame_err <= 1'b0;
        end else begin
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            frame_err <= 1'b0;

            // Read data is captured two clks after reg_rd rises.
            rd_load <= reg_rd;
            if (rd_load) tx_sr <= reg_rdata;

            // Ones seen during a frame never count toward the next preamble.
            if (state != S_IDLE) pre_cnt <= '0;

            if (rise) begin
                if (state != S_IDLE) begin
                    bit_cnt <= bit_nxt;
                    rx_sr   <= {rx_sr[DATA_W-3:0], mdi_r};
                end
                case (state)
                    S_IDLE: begin
                        if (mdi_r) begin
                            if (pre_cnt < PW'(PRE_MIN)) pre_cnt <= pre_cnt + 1'b1;
                        end else begin
                            pre_cnt <= '0;
                            if (pre_cnt >= PW'(PRE_MIN)) begin
                                state   <= S_ST;
                                bit_cnt <= 6'd1;
                            end
                        end
                    end
                    S_ST: begin
                        if ({1'b0, mdi_r} == ST) begin
                            state <= S_OP;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_OP: begin
                        if (bit_nxt == 6'd3) begin
                            op_hi <= mdi_r;
                        end else if ({op_hi, mdi_r} == OP_RD) begin
                            is_read <= 1'b1;
                            state   <= S_ADDR;
                        end else if ({op_hi, mdi_r} == OP_WR) begin
                            is_read <= 1'b0;
                            state   <= S_ADDR;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_ADDR: begin
                        if (bit_nxt == BIT_ADDR_END) begin
                            if (hdr[9:5] == PHY_ADDR) begin
                                reg_addr <= hdr[4:0];
                                reg_rd   <= is_read;
                                state    <= S_TA;
                            end else begin
                                state <= S_SKIP;
                            end
                        end
                    end
                    S_TA: begin
                        if (bit_nxt == BIT_TA1) begin
                            ta_hi <= mdi_r;
                        end else if (!is_read && ({ta_hi, mdi_r} != TA_WR)) begin
                            frame_err <= 1'b1;
                            state     <= S_SKIP;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        // Reads leave DATA on the fall after rise 32 instead.
                        if (bit_nxt == BIT_LAST && !is_read) begin
                            reg_wdata <= {rx_sr, mdi_r};
                            reg_wr    <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_SKIP: begin
                        if (bit_nxt == BIT_LAST) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (fall && is_read && (state == S_TA || state == S_DATA)) begin
                if (bit_cnt == BIT_TA1) begin
                    mdt <= 1'b1;
                    mdo <= 1'b0;
                end else if (bit_cnt == BIT_LAST) begin
                    mdt   <= 1'b0;
                    mdo   <= 1'b0;
                    state <= S_IDLE;
                end else if (bit_cnt >= BIT_TA2) begin
                    mdo   <= tx_sr[DATA_W-1];
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_slave.sv
// Directed plus randomized bench for mdio_slave acting as a station manager,
// with a register-file responder on the strobe side and an array model of
// the expected register contents.
module tb_mdio_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        m_oe = 1'b1;
    logic        m_out = 1'b1;
    logic        mdi_pin;
    logic        mdt, mdo, reg_rd, reg_wr, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_rdata, reg_wdata;

    logic [15:0] regs  [32];
    logic [15:0] model [32];

    int n_assert = 0;
    int n_fail   = 0;

    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, mdt_cnt = 0;
    logic [4:0]  last_wr_addr, last_rd_addr;
    logic [15:0] last_wdata;

    always #5 clk = ~clk;

    // Open-drain style pin with pull-up when nobody drives.
    assign mdi_pin = mdt ? mdo : (m_oe ? m_out : 1'b1);

    mdio_slave #(.PHY_ADDR(5'd1), .PRE_MIN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdi       (mdi_pin),
        .mdt       (mdt),
        .mdo       (mdo),
        .reg_addr  (reg_addr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .frame_err (frame_err)
    );

    function automatic logic [15:0] init_val(input int unsigned i);
        return (i == 2) ? 16'h1234 : (16'(i * 32'h0101) ^ 16'h5A5A);
    endfunction

    // Register file on the strobe side: one-clk read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
            reg_rdata <= '0;
        end else begin
            if (reg_rd) reg_rdata <= regs[reg_addr];
            if (reg_wr) regs[reg_addr] <= reg_wdata;
        end
    end

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt++;
            last_wr_addr = reg_addr;
            last_wdata   = reg_wdata;
        end
        if (reg_rd) begin
            rd_cnt++;
            last_rd_addr = reg_addr;
        end
        if (frame_err) err_cnt++;
        if (mdt) mdt_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One management frame with MDC half-period of 8 clks. For reads the
    // master releases the line from bit 15 and samples just before each rise
    // from 16 on: samp[16] = TA bit 2, samp[15:0] = data. abort_at != 0
    // pulses rst right after that rise and ends the frame there.
    task automatic frame(input int unsigned pre, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] ra,
                         input logic [1:0] ta, input logic [15:0] data,
                         input int unsigned abort_at,
                         output logic [16:0] samp, output logic drove);
        logic [31:0] bits;
        bits  = {2'b01, op, phy, ra, ta, data};
        samp  = '0;
        drove = 1'b1;
        m_oe  = 1'b1;
        for (int unsigned p = 0; p < pre; p++) begin
            mdc = 1'b0; m_out = 1'b1; tick(8);
            mdc = 1'b1; tick(8);
        end
        for (int i = 1; i <= 32; i++) begin
            mdc = 1'b0;
            if (op == 2'b10 && i >= 15) m_oe = 1'b0;
            else begin m_oe = 1'b1; m_out = bits[32-i]; end
            tick(8);
            if (i >= 16) begin
                samp = {samp[15:0], mdi_pin};
                if (!mdt) drove = 1'b0;
            end
            mdc = 1'b1;
            if (i == abort_at) begin
                tick(6);
                check("abort_mdt_before", 32'(mdt), 32'd1);
                rst = 1'b1;
                tick(1);
                check("abort_mdt_after", 32'(mdt), 32'd0);
                rst = 1'b0;
                m_oe = 1'b1; m_out = 1'b1;
                return;
            end
            tick(8);
        end
        mdc = 1'b0; tick(8);
        m_oe = 1'b1; m_out = 1'b1;
    endtask

    int wr0, rd0, err0, mdt0;
    task automatic snap();
        wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt; mdt0 = mdt_cnt;
    endtask

    initial begin
        logic [16:0] samp;
        logic        drove;
        logic [1:0]  op;
        logic [4:0]  phy, ra;
        logic [15:0] data;
        logic        match;

        for (int i = 0; i < 32; i++) model[i] = init_val(i);

        rst = 1'b1;
        tick(4);
        check("rst_mdt", 32'(mdt), 0);
        check("rst_mdo", 32'(mdo), 0);
        check("rst_reg_rd", 32'(reg_rd), 0);
        check("rst_reg_wr", 32'(reg_wr), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_reg_addr", 32'(reg_addr), 0);
        check("rst_reg_wdata", 32'(reg_wdata), 0);
        rst = 1'b0;
        tick(4);

        // Write 0xA5C3 to register 4.
        snap();
        frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'hA5C3, 0, samp, drove);
        model[4] = 16'hA5C3;
        check("wr_count", 32'(wr_cnt - wr0), 1);
        check("wr_addr", 32'(last_wr_addr), 4);
        check("wr_data", 32'(last_wdata), 32'hA5C3);
        check("wr_data_held", 32'(reg_wdata), 32'hA5C3);
        check("wr_no_drive", 32'(mdt_cnt - mdt0), 0);
        check("wr_no_err", 32'(err_cnt - err0), 0);

        // Read register 2.
        snap();
        frame(32, 2'b10, 5'd1, 5'd2, 2'b00, 16'h0000, 0, samp, drove);
        check("rd_count", 32'(rd_cnt - rd0), 1);
        check("rd_addr", 32'(last_rd_addr), 2);
        check("rd_ta_bit", 32'(samp[16]), 0);
        check("rd_data", 32'(samp[15:0]), 32'(model[2]));
        check("rd_drove", 32'(drove), 1);
        check("rd_mdt_released", 32'(mdt), 0);

        // Read to another PHY, then a normal read of register 4.
        snap();
        frame(32, 2'b10, 5'd3, 5'd2, 2'b00, 16'h0000, 0, samp, drove);
        check("other_phy_rd", 32'(rd_cnt - rd0), 0);
        check("other_phy_wr", 32'(wr_cnt - wr0), 0);
        check("other_phy_mdt", 32'(mdt_cnt - mdt0), 0);
        check("other_phy_err", 32'(err_cnt - err0), 0);
        snap();
        frame(32, 2'b10, 5'd1, 5'd4, 2'b00, 16'h0000, 0, samp, drove);
        check("after_other_rd_count", 32'(rd_cnt - rd0), 1);
        check("after_other_rd_data", 32'(samp[15:0]), 32'(model[4]));

        // One preamble bit short.
        snap();
        frame(31, 2'b01, 5'd1, 5'd5, 2'b10, 16'h0F00, 0, samp, drove);
        check("short_pre_wr", 32'(wr_cnt - wr0), 0);
        check("short_pre_err", 32'(err_cnt - err0), 0);

        // Illegal opcode.
        snap();
        frame(32, 2'b11, 5'd1, 5'd5, 2'b10, 16'h0F00, 0, samp, drove);
        check("op11_err", 32'(err_cnt - err0), 1);
        check("op11_wr", 32'(wr_cnt - wr0), 0);
        check("op11_rd", 32'(rd_cnt - rd0), 0);

        // Write with bad turnaround.
        snap();
        frame(32, 2'b01, 5'd1, 5'd6, 2'b11, 16'h0F0F, 0, samp, drove);
        check("bad_ta_err", 32'(err_cnt - err0), 1);
        check("bad_ta_wr", 32'(wr_cnt - wr0), 0);

        // Reset in the middle of a read, then a fresh write and readback.
        frame(32, 2'b10, 5'd1, 5'd3, 2'b00, 16'h0000, 20, samp, drove);
        for (int i = 0; i < 32; i++) model[i] = init_val(i);
        tick(4);
        snap();
        frame(32, 2'b01, 5'd1, 5'd7, 2'b10, 16'hBEEF, 0, samp, drove);
        model[7] = 16'hBEEF;
        check("post_rst_wr_count", 32'(wr_cnt - wr0), 1);
        check("post_rst_wr_addr", 32'(last_wr_addr), 7);
        check("post_rst_wr_data", 32'(last_wdata), 32'hBEEF);
        frame(32, 2'b10, 5'd1, 5'd7, 2'b00, 16'h0000, 0, samp, drove);
        check("post_rst_rd_data", 32'(samp[15:0]), 32'hBEEF);

        // Randomized frames against the register model.
        for (int n = 0; n < 16; n++) begin
            op    = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            ra    = 5'($urandom);
            data  = 16'($urandom);
            phy   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
            match = (phy == 5'd1);
            snap();
            frame(32 + $urandom_range(0, 3), op, phy, ra, 2'b10, data, 0, samp, drove);
            if (match && op == 2'b01) begin
                check("rnd_wr_count", 32'(wr_cnt - wr0), 1);
                check("rnd_wr_addr", 32'(last_wr_addr), 32'(ra));
                check("rnd_wr_data", 32'(last_wdata), 32'(data));
                model[ra] = data;
            end else if (match) begin
                check("rnd_rd_count", 32'(rd_cnt - rd0), 1);
                check("rnd_rd_ta", 32'(samp[16]), 0);
                check("rnd_rd_data", 32'(samp[15:0]), 32'(model[ra]));
                check("rnd_rd_drove", 32'(drove), 1);
            end else begin
                check("rnd_skip_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 0);
                check("rnd_skip_mdt", 32'(mdt_cnt - mdt0), 0);
            end
            check("rnd_no_err", 32'(err_cnt - err0), 0);
            check("rnd_mdt_idle", 32'(mdt), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_slave.md
# mdio_slave

PHY-side MDIO responder: receives Clause 22 management frames on MDC/MDIO, decodes them, and serves a 32 × 16-bit register space through a simple strobe interface. It sits behind the board MDIO pins, opposite the station-management master. Writes issue one `reg_wr` strobe. Reads issue one `reg_rd` strobe, then shift the returned word out on MDIO.

## Interface
- `PHY_ADDR`, default 5'd1: PHY address this block answers to.
- `PRE_MIN`, default 32: consecutive preamble ones required before ST (0 = preamble suppression).
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mdc` in 1: management clock from the master, asynchronous to `clk`.
- `mdi` in 1: MDIO pin input, asynchronous.
- `mdt` out 1: MDIO output enable (pad: mdio = mdt ? mdo : z).
- `mdo` out 1: MDIO output data.
- `reg_addr` out 5: register address of the current frame.
- `reg_rd` out 1: one-clk read strobe.
- `reg_rdata` in 16: read data; must be valid on the clk after `reg_rd`.
- `reg_wr` out 1: one-clk write strobe.
- `reg_wdata` out 16: write data; valid while `reg_wr` is high and held afterwards.
- `frame_err` out 1: one-clk pulse when a frame is aborted.

## Operation
- `mdc` and `mdi` each pass through a 2-flop synchronizer. An edge register then gives one-clk `rise`/`fall` pulses.
- Bits are sampled on `rise` and driven on `fall`.
- Frame bits are numbered from the first ST bit as rise 1..32: ST 1–2, OP 3–4, PHYAD 5–9, REGAD 10–14, TA 15–16, DATA 17–32, all MSB first.
- States: IDLE, ST, OP, ADDR, TA, DATA, SKIP.
- IDLE: count consecutive sampled ones, saturating at PRE_MIN; any zero clears the count.
  - If the count ≥ PRE_MIN and a 0 is sampled, that 0 is ST bit 1; go to ST.
  - A 0 sampled with the count < PRE_MIN: stay in IDLE, no error.
- ST: bit 2 must be 1, otherwise `frame_err` and back to IDLE.
- OP: 10 = read, 01 = write; 00 or 11 gives `frame_err` and IDLE.
- ADDR: shift in 10 bits. At rise 14, compare PHYAD with PHY_ADDR.
  - Mismatch: go to SKIP. No strobes, no drive, no error.
  - Match: latch `reg_addr`.
  - Match on a read: `reg_rd` is high for the clk after rise 14, and `reg_rdata` is loaded into the 16-bit TX shifter on the next clk.
- TA, read:
  - fall after rise 15: `mdt`=1, `mdo`=0.
  - falls after rises 16..31: `mdo` = D15..D0.
  - fall after rise 32: `mdt`=0, `mdo`=0, then IDLE.
- TA, write: the sampled TA must be 1,0. Otherwise `frame_err`, SKIP, and no `reg_wr`.
- DATA, write: shift in 16 bits. The clk after rise 32, `reg_wdata` is updated and `reg_wr` pulses; then IDLE.
- SKIP: count through to rise 32, then IDLE.
- Preamble count restarts at 0 on every return to IDLE. Ones sampled during a frame do not count.
- `mdt` is never 1 outside read-frame rises 15..32.

## Timing
- Reset values: `mdt`=0, `mdo`=0, `reg_rd`=0, `reg_wr`=0, `frame_err`=0, `reg_addr`=0, `reg_wdata`=0, state IDLE, preamble count 0.
- `rst` mid-frame releases MDIO (`mdt`=0) on the next clk and discards the frame.
- Synchronizer plus edge register: `rise`/`fall` are asserted 3 clks after the pin edge.
- `mdt`/`mdo` update on the clk after `fall`, i.e. ≤4 clks after the MDC falling pin edge.
- Requirement: MDC high and low phases ≥ 6 clk each (period ≥ 12 clk), so read data settles before the master's next rising edge.
- `reg_rd` to `reg_rdata` latency is exactly 1 clk; the block captures on the 2nd clk after `reg_rd` asserts.
- A `rise` and a `fall` never fall on the same clk, given the phase requirement above.
- MDC stopping mid-frame: state holds indefinitely and `mdt` keeps its value. Only `rst` or further MDC edges move it.

## Structure
- Package `mdio_pkg`: ST/OP constants (ST=2'b01, OP_RD=2'b10, OP_WR=2'b01), field widths, state enum, bit-index constants (14, 15, 16, 32).
- Sub-module `mdio_edge_sync`: 2-flop synchronizer on `mdc`/`mdi`, plus the `rise`/`fall` pulse generator.
- The top level holds the FSM, bit counter, preamble counter, and RX/TX shifters.

## Test plan
- Write: 32 ones, ST 01, OP 01, PHYAD 1, REGAD 0x04, TA 10, data 0xA5C3 -> one `reg_wr` with `reg_addr`=4, `reg_wdata`=0xA5C3; `mdt` stays 0.
- Read: same header with OP 10 and REGAD 0x02, `reg_rdata`=0x1234 -> one `reg_rd`, `reg_addr`=2; master samples TA bit 0 then 0x1234; `mdt` is 0 after rise 32.
- PHYAD 3 with PHY_ADDR 1, read -> no strobes, `mdt` is 0 throughout; the next frame to PHYAD 1 is handled normally.
- Only 31 preamble ones before ST -> frame ignored, no strobe, no `frame_err`.
- OP 11 -> `frame_err` pulse; write with TA 11 -> `frame_err`, no `reg_wr`.
- `rst` asserted at read-frame rise 20 -> `mdt`=0 the next clk; a fresh write frame afterwards succeeds.
